// File: rtl/hwpf_req_arbiter.sv
// hwpf_req_arbiter: merges demand and next-line prefetch requests
// onto the single HPDcache request port.
package hwpf_pkg;
  typedef logic [31:0] addr_t;
  typedef enum logic [1:0] {
    OP_LOAD, OP_STORE, OP_AMO, OP_CMO
  } hpdcache_op_e;
  typedef struct packed {
    addr_t        addr;
    hpdcache_op_e op;
    logic         uncacheable;
    logic         need_rsp;
    logic [2:0]   sid;
    logic [3:0]   tid;
  } hpdcache_req_t;
endpackage

module hwpf_req_arbiter
  import hwpf_pkg::*;
#(
  parameter int unsigned PF_DEPTH   = 4,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned STARVE_MAX = 16,
  parameter logic [2:0]  PF_SID     = '1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          lock_i,
  input  logic          pf_valid_i,
  output logic          pf_ready_o,
  input  addr_t         pf_addr_i,
  input  logic          dmd_valid_i,
  output logic          dmd_ready_o,
  input  hpdcache_req_t dmd_req_i,
  output logic          dc_valid_o,
  input  logic          dc_ready_i,
  output hpdcache_req_t dc_req_o,
  output logic [15:0]   pf_drop_cnt_o
);
  localparam int unsigned AW = $bits(addr_t);
  localparam int unsigned LB = $clog2(LINE_BYTES);
  localparam int unsigned IW = $clog2(PF_DEPTH);
  localparam int unsigned CW = $clog2(PF_DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef logic [AW-LB-1:0] line_t;
  typedef enum logic [1:0] {IDLE, HOLD_DMD, HOLD_PF} state_e;

  state_e        st_q, st_d;
  line_t         q_q [PF_DEPTH];
  line_t         q_d [PF_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stv_q, stv_d;
  line_t         hold_q, hold_d;
  logic          hin_q, hin_d;
  logic [15:0]   drop_q, drop_d;

  logic          ne, forced, sel_dmd, sel_pf;
  logic          dmd_mode, pf_mode, vld;
  logic          dmd_hs, pf_hs, pop, dup, enq, drop;
  line_t         pf_line, dmd_line, in_line;
  hpdcache_req_t pf_req;
  logic [CW-1:0] n;
  logic          pf_lo_unused;

  assign pf_lo_unused = ^pf_addr_i[LB-1:0];
  assign dmd_line = dmd_req_i.addr[AW-1:LB];
  assign in_line  = pf_addr_i[AW-1:LB];

  assign ne      = cnt_q != '0;
  assign forced  = (stv_q == SW'(STARVE_MAX)) & ne & ~lock_i;
  assign sel_dmd = dmd_valid_i & ~forced;
  assign sel_pf  = ~sel_dmd & ne & ~lock_i & ~flush_i;

  always_comb begin
    st_d     = st_q;
    vld      = 1'b0;
    dmd_mode = 1'b0;
    pf_mode  = 1'b0;
    pf_line  = q_q[0];
    unique case (st_q)
      IDLE: begin
        if (sel_dmd) begin
          dmd_mode = 1'b1;
          vld      = 1'b1;
          if (!dc_ready_i) st_d = HOLD_DMD;
        end else if (sel_pf) begin
          pf_mode = 1'b1;
          vld     = 1'b1;
          if (!dc_ready_i) st_d = HOLD_PF;
        end
      end
      HOLD_DMD: begin
        dmd_mode = 1'b1;
        vld      = 1'b1;
        if (dc_ready_i) st_d = IDLE;
      end
      HOLD_PF: begin
        pf_line = hold_q;
        // flush is the one case allowed to withdraw a presented request
        if (flush_i) begin
          st_d = IDLE;
        end else begin
          pf_mode = 1'b1;
          vld     = 1'b1;
          if (dc_ready_i) st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    pf_req      = '0;
    pf_req.addr = {pf_line, {LB{1'b0}}};
    pf_req.op   = OP_LOAD;
    pf_req.sid  = PF_SID;
  end

  assign dc_valid_o  = vld & ~rst_i;
  assign dmd_ready_o = dmd_mode & dc_ready_i & ~rst_i;
  assign dc_req_o    = pf_mode ? pf_req : dmd_req_i;
  assign pf_ready_o  = ~lock_i & ~flush_i;

  assign dmd_hs = dmd_mode & dc_ready_i;
  assign pf_hs  = pf_mode & dc_ready_i;
  assign pop    = pf_hs & ((st_q == IDLE) | hin_q);

  always_comb begin
    dup = dmd_hs & (dmd_line == in_line);
    for (int unsigned i = 0; i < PF_DEPTH; i++) begin
      if (CW'(i) < cnt_q && q_q[i] == in_line) dup = 1'b1;
    end
    enq = pf_valid_i & pf_ready_o & ~dup;
  end

  // pop, purge and compaction first, then append at the tail
  always_comb begin
    q_d  = q_q;
    n    = '0;
    drop = 1'b0;
    for (int unsigned i = 0; i < PF_DEPTH; i++) begin
      if (CW'(i) < cnt_q && !(pop && i == 0) &&
          !(dmd_hs && q_q[i] == dmd_line)) begin
        q_d[n[IW-1:0]] = q_q[i];
        n = n + 1'b1;
      end
    end
    if (enq) begin
      if (n == CW'(PF_DEPTH)) begin
        drop = 1'b1;
        for (int unsigned i = 0; i < PF_DEPTH - 1; i++) begin
          q_d[i] = q_d[i+1];
        end
        q_d[PF_DEPTH-1] = in_line;
      end else begin
        q_d[n[IW-1:0]] = in_line;
        n = n + 1'b1;
      end
    end
    cnt_d = flush_i ? '0 : n;
  end

  always_comb begin
    hold_d = hold_q;
    hin_d  = hin_q;
    if (st_q == IDLE && pf_mode && !dc_ready_i) begin
      hold_d = q_q[0];
      hin_d  = ~drop;
    end else if (st_q == HOLD_PF) begin
      hin_d = hin_q & ~drop;
    end
    if (flush_i) hin_d = 1'b0;
  end

  always_comb begin
    stv_d = stv_q;
    if (pf_hs) begin
      stv_d = '0;
    end else if (dmd_hs && ne && stv_q != SW'(STARVE_MAX)) begin
      stv_d = stv_q + 1'b1;
    end
    if (flush_i) stv_d = '0;
    drop_d = drop_q;
    if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  assign pf_drop_cnt_o = drop_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      stv_q  <= '0;
      hold_q <= '0;
      hin_q  <= 1'b0;
      drop_q <= '0;
      for (int unsigned i = 0; i < PF_DEPTH; i++) q_q[i] <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      stv_q  <= stv_d;
      hold_q <= hold_d;
      hin_q  <= hin_d;
      drop_q <= drop_d;
      q_q    <= q_d;
    end
  end
endmodule

// File: tb/tb_hwpf_req_arbiter.sv
// tb_hwpf_req_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_hwpf_req_arbiter;
  import hwpf_pkg::*;

  localparam int D    = 4;
  localparam int LB   = 6;
  localparam int SMAX = 16;
  localparam logic [2:0] PSID = 3'b111;

  typedef logic [31-LB:0] ln_t;

  logic          clk = 1'b0;
  logic          rst, flush, lock;
  logic          pf_valid, pf_ready;
  addr_t         pf_addr;
  logic          dmd_valid, dmd_ready;
  hpdcache_req_t dmd_req, dc_req;
  logic          dc_valid, dc_ready;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  hwpf_req_arbiter #(
    .PF_DEPTH(D), .LINE_BYTES(64), .STARVE_MAX(SMAX), .PF_SID(PSID)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .lock_i(lock),
    .pf_valid_i(pf_valid), .pf_ready_o(pf_ready), .pf_addr_i(pf_addr),
    .dmd_valid_i(dmd_valid), .dmd_ready_o(dmd_ready),
    .dmd_req_i(dmd_req), .dc_valid_o(dc_valid), .dc_ready_i(dc_ready),
    .dc_req_o(dc_req), .pf_drop_cnt_o(drop_cnt)
  );

  int tests = 0;
  int fails = 0;

  // reference model: 0 idle, 1 demand held, 2 prefetch held
  ln_t mq[$];
  int  m_mode = 0;
  ln_t m_hold;
  bit  m_hin;
  int  m_stv = 0;
  int  m_drop = 0;

  bit            e_v, e_pf, e_hs;
  hpdcache_req_t e_req;
  bit            last_v, last_hs, last_dr;
  addr_t         last_addr;
  logic [2:0]    last_sid;

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  function automatic hpdcache_req_t mk_dmd(input addr_t a);
    hpdcache_req_t r;
    r = '0;
    r.addr = a;
    r.op = OP_LOAD;
    r.need_rsp = 1'b1;
    r.tid = a[5:2];
    return r;
  endfunction

  function automatic hpdcache_req_t mk_pf(input ln_t l);
    hpdcache_req_t r;
    r = '0;
    r.addr = {l, 6'b0};
    r.op = OP_LOAD;
    r.sid = PSID;
    return r;
  endfunction

  task automatic model_eval();
    bit ne, forced;
    ne = mq.size() > 0;
    forced = (m_stv >= SMAX) && ne && !lock;
    e_v = 0;
    e_pf = 0;
    e_req = dmd_req;
    case (m_mode)
      0: begin
        if (dmd_valid && !forced) e_v = 1;
        else if (ne && !lock && !flush) begin
          e_v = 1;
          e_pf = 1;
          e_req = mk_pf(mq[0]);
        end
      end
      1: e_v = 1;
      default: begin
        if (!flush) begin
          e_v = 1;
          e_pf = 1;
          e_req = mk_pf(m_hold);
        end
      end
    endcase
    e_hs = e_v && dc_ready;
  endtask

  task automatic model_upd();
    ln_t orig[$];
    ln_t pl, dl;
    bit  dup, dropped;
    orig = mq;
    pl = pf_addr[31:LB];
    dl = dmd_req.addr[31:LB];
    dropped = 0;
    if (e_hs && e_pf) begin
      m_stv = 0;
      if (m_mode == 0 || m_hin) void'(mq.pop_front());
    end
    if (e_hs && !e_pf) begin
      if (orig.size() > 0 && m_stv < SMAX) m_stv++;
      mq = mq.find(x) with (x != dl);
    end
    if (pf_valid && !lock && !flush) begin
      dup = e_hs && !e_pf && (dl == pl);
      foreach (orig[i]) if (orig[i] == pl) dup = 1;
      if (!dup) begin
        if (mq.size() == D) begin
          void'(mq.pop_front());
          dropped = 1;
          if (m_drop < 65535) m_drop++;
        end
        mq.push_back(pl);
      end
    end
    if (flush) begin
      mq.delete();
      m_stv = 0;
    end
    case (m_mode)
      0: begin
        if (e_v && !e_hs) begin
          m_mode = e_pf ? 2 : 1;
          if (e_pf) begin
            m_hold = orig[0];
            m_hin = !dropped;
          end
        end
      end
      1: if (e_hs) m_mode = 0;
      default: begin
        if (flush || e_hs) m_mode = 0;
        else if (dropped) m_hin = 0;
      end
    endcase
  endtask

  task automatic step(input bit pv, input addr_t pa, input bit dv,
                      input addr_t da, input bit rdy, input bit fl,
                      input bit lk);
    pf_valid = pv;
    pf_addr = pa;
    dmd_valid = dv;
    dmd_req = mk_dmd(da);
    dc_ready = rdy;
    flush = fl;
    lock = lk;
    @(negedge clk);
    model_eval();
    chk("dc_valid", 64'(dc_valid), 64'(e_v));
    if (e_v) chk("dc_req", 64'(dc_req), 64'(e_req));
    chk("dmd_ready", 64'(dmd_ready), 64'(e_v && !e_pf && rdy));
    chk("pf_ready", 64'(pf_ready), 64'(!lk && !fl));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    last_v = dc_valid;
    last_hs = dc_valid && dc_ready;
    last_dr = dmd_ready;
    last_addr = dc_req.addr;
    last_sid = dc_req.sid;
    @(posedge clk);
    model_upd();
    #1;
  endtask

  initial begin
    int    n, npf;
    bit    got, dv;
    addr_t da;
    rst = 1;
    flush = 0;
    lock = 0;
    pf_valid = 0;
    pf_addr = '0;
    dmd_valid = 1;
    dmd_req = mk_dmd(32'h100);
    dc_ready = 1;
    last_dr = 0;
    @(negedge clk);
    chk("rst_dc_valid", 64'(dc_valid), 64'(0));
    chk("rst_dmd_ready", 64'(dmd_ready), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    @(posedge clk);
    #1 rst = 0;

    // T1: first prefetch one cycle after acceptance
    step(1, 32'h1000, 0, 0, 1, 0, 0);
    chk("t1_no_bypass", 64'(last_v), 64'(0));
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t1_valid", 64'(last_v), 64'(1));
    chk("t1_addr", 64'(last_addr), 64'(32'h1000));
    chk("t1_sid", 64'(last_sid), 64'(PSID));

    // T2: same-line dedup
    step(1, 32'h1040, 0, 0, 0, 0, 0);
    step(1, 32'h1050, 0, 0, 0, 0, 0);
    step(1, 32'h1040, 0, 0, 0, 0, 0);
    npf = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      if (last_hs && last_sid == PSID && last_addr == 32'h1040) npf++;
    end
    chk("t2_one_pf", 64'(npf), 64'(1));

    // T3: overflow while a demand is held
    step(0, 0, 1, 32'h9000, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      step(1, 32'h5000 + 32'(k * 64), 1, 32'h9000, 0, 0, 0);
    chk("t3_drop", 64'(drop_cnt), 64'(1));
    step(0, 0, 1, 32'h9000, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      chk("t3_order", 64'(last_addr), 64'(32'h5040 + 32'(k * 64)));
      chk("t3_sid", 64'(last_sid), 64'(PSID));
    end

    // T4: starvation forces one prefetch slot
    step(1, 32'h2000, 1, 32'hA000, 1, 0, 0);
    n = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(0, 0, 1, 32'hA000, 1, 0, 0);
      if (last_v && last_sid == PSID) got = 1;
      else if (last_dr) n++;
    end
    chk("t4_grants", 64'(n), 64'(SMAX));
    chk("t4_pf_seen", 64'(got), 64'(1));
    chk("t4_pf_addr", 64'(last_addr), 64'(32'h2000));
    step(0, 0, 1, 32'hA000, 1, 0, 0);
    chk("t4_resume", 64'(last_dr), 64'(1));

    // T5: held prefetch is not preempted
    step(1, 32'h3000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t5_present", 64'(last_addr), 64'(32'h3000));
    step(0, 0, 1, 32'hC000, 0, 0, 0);
    chk("t5_stable", 64'(last_addr), 64'(32'h3000));
    chk("t5_no_dmd", 64'(last_dr), 64'(0));
    step(0, 0, 1, 32'hC000, 1, 0, 0);
    chk("t5_pf_hs", 64'(last_hs && last_sid == PSID), 64'(1));
    step(0, 0, 1, 32'hC000, 1, 0, 0);
    chk("t5_dmd_next", 64'(last_dr), 64'(1));

    // T6: demand purge, then flush during a held prefetch
    step(1, 32'h4000, 0, 0, 1, 0, 0);
    step(0, 0, 1, 32'h4008, 1, 0, 0);
    chk("t6_dmd", 64'(last_dr), 64'(1));
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t6_purged", 64'(last_v), 64'(0));
    step(1, 32'h4400, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t6_hold", 64'(last_v), 64'(1));
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t6_flush_now", 64'(last_v), 64'(0));
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t6_flush_next", 64'(last_v), 64'(0));

    // randomized traffic; demand source holds until accepted
    dv = 0;
    da = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!(dv && !last_dr)) begin
        dv = ($urandom_range(0, 2) == 0);
        da = 32'h8000 + ($urandom_range(0, 7) << 6)
           + $urandom_range(0, 63);
      end
      step(1'($urandom_range(0, 1)),
           32'h8000 + ($urandom_range(0, 7) << 6)
           + $urandom_range(0, 63),
           dv, da, 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
    end

    // reset in the middle of a held demand
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 32'hB000, 0, 0, 0);
    rst = 1;
    #1;
    chk("rst_mid_valid", 64'(dc_valid), 64'(0));
    chk("rst_mid_ready", 64'(dmd_ready), 64'(0));
    chk("rst_mid_drop", 64'(drop_cnt), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
